mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 102 ++++++++++
 tb/tb_mem_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Fixed-latency single-port memory responder: accepts one request at a time,
// performs the access LATENCY edges later and pulses MEM_READY for one cycle.
module mem_responder #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        trans,
  input  logic        MEMW,
  input  logic [11:0] MEM_ADDR,
  input  logic [31:0] MEM_DI,
  output logic [31:0] MEM_DOUT,
  output logic        MEM_READY,
  output logic        MEM_BUSY
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [9:0]  word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] dout_q, dout_d;
  logic [31:0] mem_q [1024];
  logic        accept;
  logic        access;
  logic        unused_addr_bits;

  // Byte-lane bits are don't-care: sub-word addresses alias to one word.
  assign unused_addr_bits = ^MEM_ADDR[1:0];

  assign accept = (state_q == StIdle) && trans;
  assign access = (state_q == StBusy) && (cnt_q == 4'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (trans) state_d = StBusy;
      StBusy:  if (cnt_q == 4'd1) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    MEM_BUSY  = (state_q != StIdle);
    MEM_READY = (state_q == StResp);
    MEM_DOUT  = dout_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    if (accept) begin
      cnt_d   = 4'(LATENCY);
      we_d    = MEMW;
      word_d  = MEM_ADDR[11:2];
      wdata_d = MEM_DI;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (access && !we_q) begin
      dout_d = mem_q[word_q];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      word_q  <= 10'd0;
      wdata_q <= 32'd0;
      dout_q  <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
    end
  end

  // Array is deliberately left out of reset; an aborted request never reaches access.
  always_ff @(posedge clk) begin
    if (access && we_q) begin
      mem_q[word_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: requests push expected MEM_DOUT values,
// a monitor pops and compares on every MEM_READY pulse.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        trans = 1'b0;
  logic        memw = 1'b0;
  logic [11:0] addr = 12'd0;
  logic [31:0] di = 32'd0;
  logic [31:0] dout;
  logic        ready;
  logic        busy;

  logic        trans1 = 1'b0;
  logic        memw1 = 1'b0;
  logic [11:0] addr1 = 12'd0;
  logic [31:0] di1 = 32'd0;
  logic [31:0] dout1;
  logic        ready1;
  logic        busy1;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(4)) dut (
    .clk(clk), .rstn(rstn), .trans(trans), .MEMW(memw), .MEM_ADDR(addr), .MEM_DI(di),
    .MEM_DOUT(dout), .MEM_READY(ready), .MEM_BUSY(busy)
  );

  mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn), .trans(trans1), .MEMW(memw1), .MEM_ADDR(addr1), .MEM_DI(di1),
    .MEM_DOUT(dout1), .MEM_READY(ready1), .MEM_BUSY(busy1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: each READY pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready: got dout %h want no response", dout);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          bad++;
          $display("FAIL resp_dout: got %h want %h", dout, e);
        end
      end
    end
  end

  // One request on the LATENCY=4 instance; optionally inject a write while busy.
  task automatic req(input logic w, input logic [11:0] a, input logic [31:0] d,
                     input logic [31:0] exp_dout, input bit glitch);
    exp_q.push_back(exp_dout);
    trans = 1'b1; memw = w; addr = a; di = d;
    @(posedge clk); #1;
    check("busy_after_e0", {31'd0, busy}, 32'd1);
    check("ready_after_e0", {31'd0, ready}, 32'd0);
    trans = 1'b0; memw = ~w; addr = 12'hABC; di = 32'hFFFF_FFFF;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (glitch && k == 2) begin
        trans = 1'b1; memw = 1'b1; addr = 12'h020; di = 32'h0000_0055;
      end
      check("ready_window", {31'd0, ready}, (k == 4) ? 32'd1 : 32'd0);
      check("busy_window", {31'd0, busy}, 32'd1);
    end
    trans = 1'b0;
    @(posedge clk); #1;
    check("ready_after_resp", {31'd0, ready}, 32'd0);
    check("busy_after_resp", {31'd0, busy}, 32'd0);
    check("dout_hold", dout, exp_dout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_dout", dout, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    req(1'b1, 12'h010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    req(1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    req(1'b0, 12'h013, 32'h0, 32'hDEAD_BEEF, 1'b0);
    req(1'b1, 12'h020, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0);

    // Reset abort of a write in flight.
    trans = 1'b1; memw = 1'b1; addr = 12'h020; di = 32'h2222_2222;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_dout", dout, 32'd0);
    trans = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    req(1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF, 1'b1);
    req(1'b0, 12'h020, 32'h0, 32'h1111_1111, 1'b0);

    req(1'b1, 12'hFFC, 32'hA5A5_A5A5, 32'h1111_1111, 1'b0);
    req(1'b1, 12'h000, 32'h5A5A_5A5A, 32'h1111_1111, 1'b0);
    req(1'b0, 12'hFFC, 32'h0, 32'hA5A5_A5A5, 1'b0);
    req(1'b0, 12'h000, 32'h0, 32'h5A5A_5A5A, 1'b0);

    // Back-to-back reads with trans held: READY every 6 cycles.
    repeat (3) exp_q.push_back(32'h5A5A_5A5A);
    trans = 1'b1; memw = 1'b0; addr = 12'h000;
    @(posedge clk); #1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      check("b2b_ready", {31'd0, ready}, (k % 6 == 4) ? 32'd1 : 32'd0);
      if (k == 16) trans = 1'b0;
    end
    check("b2b_idle", {31'd0, busy}, 32'd0);

    // LATENCY=1 instance: write then read back.
    trans1 = 1'b1; memw1 = 1'b1; addr1 = 12'h004; di1 = 32'h0000_1234;
    @(posedge clk); #1;
    check("l1_busy_e0", {31'd0, busy1}, 32'd1);
    check("l1_ready_e0", {31'd0, ready1}, 32'd0);
    trans1 = 1'b0;
    @(posedge clk); #1;
    check("l1_ready_e1", {31'd0, ready1}, 32'd1);
    @(posedge clk); #1;
    check("l1_ready_e2", {31'd0, ready1}, 32'd0);
    check("l1_busy_e2", {31'd0, busy1}, 32'd0);
    check("l1_dout_wr", dout1, 32'd0);
    trans1 = 1'b1; memw1 = 1'b0; addr1 = 12'h006;
    @(posedge clk); #1;
    trans1 = 1'b0;
    @(posedge clk); #1;
    check("l1_rd_ready", {31'd0, ready1}, 32'd1);
    check("l1_rd_dout", dout1, 32'h0000_1234);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
